// File: rtl/alu_system_pkg.sv
// rtl/alu_system_pkg.sv - shared encodings for the course CPU datapath
package alu_system_pkg;

  // Register function codes shared by RF, ARF and IR
  typedef enum logic [1:0] {
    FUN_DEC   = 2'b00,
    FUN_INC   = 2'b01,
    FUN_LOAD  = 2'b10,
    FUN_CLEAR = 2'b11
  } reg_fun_e;

  // ALU operation codes
  typedef enum logic [3:0] {
    ALU_A     = 4'h0,
    ALU_B     = 4'h1,
    ALU_NOT_A = 4'h2,
    ALU_NOT_B = 4'h3,
    ALU_ADD   = 4'h4,
    ALU_ADC   = 4'h5,
    ALU_SUB   = 4'h6,
    ALU_AND   = 4'h7,
    ALU_OR    = 4'h8,
    ALU_XOR   = 4'h9,
    ALU_LSL   = 4'hA,
    ALU_LSR   = 4'hB,
    ALU_ASL   = 4'hC,
    ALU_ASR   = 4'hD,
    ALU_CSL   = 4'hE,
    ALU_CSR   = 4'hF
  } alu_op_e;

  // MuxA / MuxB source selects
  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_MEM = 2'b01;
  localparam logic [1:0] MUX_IR  = 2'b10;
  localparam logic [1:0] MUX_ARF = 2'b11;

  // MuxC source selects
  localparam logic MUXC_RF  = 1'b0;
  localparam logic MUXC_ARF = 1'b1;

  // ARF read-port selects (both 10 and 11 pick PC)
  localparam logic [1:0] ARF_SEL_AR = 2'b00;
  localparam logic [1:0] ARF_SEL_SP = 2'b01;

  // Flag nibble bit positions
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

endpackage

// File: rtl/alu_system_register.sv
// rtl/alu_system_register.sv - N-bit register with dec/inc/load/clear functions
module n_bit_register
  import alu_system_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         E,
  input  logic [1:0]   FunSel,
  input  logic [N-1:0] I,
  output logic [N-1:0] Q
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Apply the selected function when enabled, otherwise hold
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Q <= '0;
    end else if (E) begin
      case (FunSel)
        FUN_DEC:  Q <= Q - ONE;
        FUN_INC:  Q <= Q + ONE;
        FUN_LOAD: Q <= I;
        default:  Q <= '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_system.sv
// rtl/alu_system.sv - 8-bit datapath: RF, ARF, IR, ALU with flags, RAM and muxes
module alu_system
  import alu_system_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [1:0] RF_OutASel,
  input  logic [1:0] RF_OutBSel,
  input  logic [1:0] RF_FunSel,
  input  logic [3:0] RF_RegSel,
  input  logic [3:0] ALU_FunSel,
  input  logic [1:0] ARF_OutCSel,
  input  logic [1:0] ARF_OutDSel,
  input  logic [1:0] ARF_FunSel,
  input  logic [2:0] ARF_RegSel,
  input  logic       IR_LH,
  input  logic       IR_Enable,
  input  logic [1:0] IR_Funsel,
  input  logic       Mem_WR,
  input  logic       Mem_CS,
  input  logic [1:0] MuxASel,
  input  logic [1:0] MuxBSel,
  input  logic       MuxCSel
);

  logic [7:0]  R1, R2, R3, R4, PC, AR, SP;
  logic [7:0]  AOut, BOut, ALUOut, ARF_COut, Address, MemoryOut;
  logic [7:0]  MuxAOut, MuxBOut, MuxCOut;
  logic [3:0]  ALUOutFlag, flag_next;
  logic [15:0] IROut, ir_step;
  logic [7:0]  ir_hi_in, ir_lo_in, b_add;
  logic        ir_load, ir_hi_en, ir_lo_en, carry_in;
  logic [8:0]  sum;
  logic [7:0]  mem [256];

  // General register file; RegSel is active-low
  n_bit_register #(.N(8)) u_r1 (.Clock(Clock), .Reset_n(Reset_n), .E(~RF_RegSel[3]), .FunSel(RF_FunSel), .I(MuxAOut), .Q(R1));
  n_bit_register #(.N(8)) u_r2 (.Clock(Clock), .Reset_n(Reset_n), .E(~RF_RegSel[2]), .FunSel(RF_FunSel), .I(MuxAOut), .Q(R2));
  n_bit_register #(.N(8)) u_r3 (.Clock(Clock), .Reset_n(Reset_n), .E(~RF_RegSel[1]), .FunSel(RF_FunSel), .I(MuxAOut), .Q(R3));
  n_bit_register #(.N(8)) u_r4 (.Clock(Clock), .Reset_n(Reset_n), .E(~RF_RegSel[0]), .FunSel(RF_FunSel), .I(MuxAOut), .Q(R4));

  // Address register file
  n_bit_register #(.N(8)) u_pc (.Clock(Clock), .Reset_n(Reset_n), .E(~ARF_RegSel[2]), .FunSel(ARF_FunSel), .I(MuxBOut), .Q(PC));
  n_bit_register #(.N(8)) u_ar (.Clock(Clock), .Reset_n(Reset_n), .E(~ARF_RegSel[1]), .FunSel(ARF_FunSel), .I(MuxBOut), .Q(AR));
  n_bit_register #(.N(8)) u_sp (.Clock(Clock), .Reset_n(Reset_n), .E(~ARF_RegSel[0]), .FunSel(ARF_FunSel), .I(MuxBOut), .Q(SP));

  // RF read ports
  always_comb begin
    case (RF_OutASel)
      2'b00:   AOut = R1;
      2'b01:   AOut = R2;
      2'b10:   AOut = R3;
      default: AOut = R4;
    endcase
    case (RF_OutBSel)
      2'b00:   BOut = R1;
      2'b01:   BOut = R2;
      2'b10:   BOut = R3;
      default: BOut = R4;
    endcase
  end

  // ARF read ports; C feeds muxes, D addresses memory
  always_comb begin
    case (ARF_OutCSel)
      ARF_SEL_AR: ARF_COut = AR;
      ARF_SEL_SP: ARF_COut = SP;
      default:    ARF_COut = PC;
    endcase
    case (ARF_OutDSel)
      ARF_SEL_AR: Address = AR;
      ARF_SEL_SP: Address = SP;
      default:    Address = PC;
    endcase
  end

  // IR halves always load; inc/dec/clear are computed on the full 16 bits
  // here so a carry or borrow crosses the byte boundary
  always_comb begin
    ir_load = (IR_Funsel == FUN_LOAD);
    case (IR_Funsel)
      FUN_DEC: ir_step = IROut - 16'd1;
      FUN_INC: ir_step = IROut + 16'd1;
      default: ir_step = 16'd0;
    endcase
    ir_hi_in = ir_load ? MemoryOut : ir_step[15:8];
    ir_lo_in = ir_load ? MemoryOut : ir_step[7:0];
    ir_hi_en = IR_Enable & (~ir_load | IR_LH);
    ir_lo_en = IR_Enable & (~ir_load | ~IR_LH);
  end

  n_bit_register #(.N(8)) u_ir_hi (.Clock(Clock), .Reset_n(Reset_n), .E(ir_hi_en), .FunSel(FUN_LOAD), .I(ir_hi_in), .Q(IROut[15:8]));
  n_bit_register #(.N(8)) u_ir_lo (.Clock(Clock), .Reset_n(Reset_n), .E(ir_lo_en), .FunSel(FUN_LOAD), .I(ir_lo_in), .Q(IROut[7:0]));

  // Source muxes
  always_comb begin
    case (MuxASel)
      MUX_ALU: MuxAOut = ALUOut;
      MUX_MEM: MuxAOut = MemoryOut;
      MUX_IR:  MuxAOut = IROut[7:0];
      default: MuxAOut = ARF_COut;
    endcase
    case (MuxBSel)
      MUX_ALU: MuxBOut = ALUOut;
      MUX_MEM: MuxBOut = MemoryOut;
      MUX_IR:  MuxBOut = IROut[7:0];
      default: MuxBOut = ARF_COut;
    endcase
    MuxCOut = (MuxCSel == MUXC_ARF) ? ARF_COut : AOut;
  end

  // ALU result and next flags; one shared adder serves add, adc and sub
  always_comb begin
    flag_next = ALUOutFlag;
    ALUOut    = MuxCOut;
    b_add     = (ALU_FunSel == ALU_SUB) ? ~BOut : BOut;
    carry_in  = (ALU_FunSel == ALU_SUB) | ((ALU_FunSel == ALU_ADC) & ALUOutFlag[FLAG_C]);
    sum       = {1'b0, MuxCOut} + {1'b0, b_add} + {8'd0, carry_in};
    case (ALU_FunSel)
      ALU_A:     ALUOut = MuxCOut;
      ALU_B:     ALUOut = BOut;
      ALU_NOT_A: ALUOut = ~MuxCOut;
      ALU_NOT_B: ALUOut = ~BOut;
      ALU_ADD, ALU_ADC, ALU_SUB: begin
        ALUOut            = sum[7:0];
        flag_next[FLAG_C] = sum[8];
        flag_next[FLAG_O] = (MuxCOut[7] == b_add[7]) && (sum[7] != MuxCOut[7]);
      end
      ALU_AND:   ALUOut = MuxCOut & BOut;
      ALU_OR:    ALUOut = MuxCOut | BOut;
      ALU_XOR:   ALUOut = MuxCOut ^ BOut;
      ALU_LSL: begin
        ALUOut            = {MuxCOut[6:0], 1'b0};
        flag_next[FLAG_C] = MuxCOut[7];
      end
      ALU_LSR: begin
        ALUOut            = {1'b0, MuxCOut[7:1]};
        flag_next[FLAG_C] = MuxCOut[0];
      end
      ALU_ASL: begin
        ALUOut            = {MuxCOut[6:0], 1'b0};
        flag_next[FLAG_C] = MuxCOut[7];
        flag_next[FLAG_O] = MuxCOut[7] ^ MuxCOut[6];
      end
      ALU_ASR: begin
        ALUOut            = {MuxCOut[7], MuxCOut[7:1]};
        flag_next[FLAG_C] = MuxCOut[0];
      end
      ALU_CSL: begin
        ALUOut            = {MuxCOut[6:0], ALUOutFlag[FLAG_C]};
        flag_next[FLAG_C] = MuxCOut[7];
      end
      ALU_CSR: begin
        ALUOut            = {ALUOutFlag[FLAG_C], MuxCOut[7:1]};
        flag_next[FLAG_C] = MuxCOut[0];
      end
      default: ALUOut = MuxCOut;
    endcase
    flag_next[FLAG_Z] = (ALUOut == 8'd0);
    flag_next[FLAG_N] = ALUOut[7];
  end

  // Flag nibble register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ALUOutFlag <= 4'd0;
    end else begin
      ALUOutFlag <= flag_next;
    end
  end

  // RAM write on the edge; contents survive reset, writes are blocked during it
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (Reset_n && !Mem_CS && Mem_WR) begin
      mem[Address] <= ALUOut;
    end
  end

  // Combinational RAM read, zero when not reading
  always_comb begin
    MemoryOut = (!Mem_CS && !Mem_WR) ? mem[Address] : 8'd0;
  end

endmodule

// File: tb/tb_alu_system.sv
// tb/tb_alu_system.sv - vector and random-model checks for alu_system
module tb_alu_system;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [1:0] RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0] RF_RegSel, ALU_FunSel;
  logic [1:0] ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [2:0] ARF_RegSel;
  logic       IR_LH, IR_Enable;
  logic [1:0] IR_Funsel;
  logic       Mem_WR, Mem_CS;
  logic [1:0] MuxASel, MuxBSel;
  logic       MuxCSel;
  bit         clk_run = 1'b0;

  int errors = 0;
  int checks = 0;

  alu_system dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel), .RF_RegSel(RF_RegSel),
    .ALU_FunSel(ALU_FunSel),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel)
  );

  always #5 if (clk_run) Clock = ~Clock;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs[13];

  // behavioural model state
  logic [7:0]  m_rf [4];
  logic [7:0]  m_pc, m_ar, m_sp;
  logic [15:0] m_ir;
  logic [3:0]  m_flags;
  logic [7:0]  m_mem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    RF_OutASel = 0; RF_OutBSel = 0; RF_FunSel = 0; RF_RegSel = 4'hF;
    ALU_FunSel = 0; ARF_OutCSel = 0; ARF_OutDSel = 0; ARF_FunSel = 0; ARF_RegSel = 3'h7;
    IR_LH = 0; IR_Enable = 0; IR_Funsel = 0; Mem_WR = 0; Mem_CS = 1;
    MuxASel = 0; MuxBSel = 0; MuxCSel = 0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Reach an arbitrary value using only clear and inc/dec
  task automatic load_rf(input int idx, input int val);
    idle();
    RF_RegSel = ~(4'b1000 >> idx);
    RF_FunSel = 2'b11;
    tick();
    if (val < 128) begin
      RF_FunSel = 2'b01;
      repeat (val) tick();
    end else begin
      RF_FunSel = 2'b00;
      repeat (256 - val) tick();
    end
    idle();
  endtask

  function automatic logic [7:0] reg_fun(input logic [1:0] f, input int q, input logic [7:0] d);
    int v;
    case (f)
      2'b00:   v = (q + 255) % 256;
      2'b01:   v = (q + 1) % 256;
      2'b10:   v = d;
      default: v = 0;
    endcase
    return v[7:0];
  endfunction

  function automatic void alu_model(input logic [3:0] op, input int a, input int b,
                                    input logic [3:0] fin, output logic [7:0] res, output logic [3:0] fout);
    int r, s, sa, sb, cin;
    logic c, o;
    c = fin[2]; o = fin[0];
    cin = fin[2] ? 1 : 0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    r = 0;
    case (op)
      4'h0: r = a;
      4'h1: r = b;
      4'h2: r = 255 - a;
      4'h3: r = 255 - b;
      4'h4: begin s = a + b; r = s % 256; c = (s > 255); o = (sa + sb > 127) || (sa + sb < -128); end
      4'h5: begin s = a + b + cin; r = s % 256; c = (s > 255); o = (sa + sb + cin > 127) || (sa + sb + cin < -128); end
      4'h6: begin s = a + (255 - b) + 1; r = s % 256; c = (s > 255); o = (sa - sb > 127) || (sa - sb < -128); end
      4'h7: r = a & b;
      4'h8: r = a | b;
      4'h9: r = a ^ b;
      4'hA: begin r = (a * 2) % 256; c = (a >= 128); end
      4'hB: begin r = a / 2; c = (a % 2 == 1); end
      4'hC: begin r = (a * 2) % 256; c = (a >= 128); o = ((a >= 128) != (r >= 128)); end
      4'hD: begin r = a / 2 + ((a >= 128) ? 128 : 0); c = (a % 2 == 1); end
      4'hE: begin r = (a * 2) % 256 + cin; c = (a >= 128); end
      default: begin r = a / 2 + cin * 128; c = (a % 2 == 1); end
    endcase
    res  = r[7:0];
    fout = {(r == 0), c, (r >= 128), o};
  endfunction

  function automatic logic [7:0] arf_pick(input logic [1:0] sel);
    if (sel == 2'b00) return m_ar;
    if (sel == 2'b01) return m_sp;
    return m_pc;
  endfunction

  initial begin
    logic [31:0] r, r2;
    logic [7:0]  e_a, e_b, e_c, e_d, e_mc, e_alu, e_mem, e_mux_a, e_mux_b;
    logic [3:0]  e_flags;

    vecs[0]  = '{4'h4, 8'h80, 8'h80, 1'b0, 8'h00, 4'b1101};
    vecs[1]  = '{4'h4, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011};
    vecs[2]  = '{4'h5, 8'h10, 8'h20, 1'b1, 8'h31, 4'b0000};
    vecs[3]  = '{4'h6, 8'h05, 8'h07, 1'b1, 8'hFE, 4'b0010};
    vecs[4]  = '{4'h6, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0101};
    vecs[5]  = '{4'h7, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0100};
    vecs[6]  = '{4'h9, 8'hAA, 8'hAA, 1'b0, 8'h00, 4'b1000};
    vecs[7]  = '{4'hC, 8'h40, 8'h00, 1'b0, 8'h80, 4'b0011};
    vecs[8]  = '{4'hD, 8'h81, 8'h00, 1'b0, 8'hC0, 4'b0110};
    vecs[9]  = '{4'hF, 8'h01, 8'h00, 1'b0, 8'h00, 4'b1100};
    vecs[10] = '{4'hE, 8'h80, 8'h00, 1'b1, 8'h01, 4'b0100};
    vecs[11] = '{4'h2, 8'h0F, 8'h00, 1'b0, 8'hF0, 4'b0010};
    vecs[12] = '{4'hB, 8'h01, 8'h00, 1'b0, 8'h00, 4'b1100};

    // reset with the clock stopped
    idle();
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    #2;
    chk("reset_rf", {dut.R1, dut.R2, dut.R3, dut.R4}, 32'h0);
    chk("reset_arf", {8'h0, dut.PC, dut.AR, dut.SP}, 32'h0);
    chk("reset_ir", {16'h0, dut.IROut}, 32'h0);
    chk("reset_flags", {28'h0, dut.ALUOutFlag}, 32'h0);
    chk("reset_address", {24'h0, dut.Address}, 32'h0);
    Reset_n = 1'b1;
    #1 clk_run = 1'b1;
    tick();

    // PC count and wrap
    ARF_RegSel = 3'b011; ARF_FunSel = 2'b01; ARF_OutDSel = 2'b10;
    repeat (3) tick();
    chk("pc_count", {24'h0, dut.Address}, 32'h03);
    ARF_FunSel = 2'b11; tick();
    ARF_FunSel = 2'b00; tick();
    chk("pc_wrap", {24'h0, dut.Address}, 32'hFF);
    ARF_FunSel = 2'b11; tick();
    ARF_FunSel = 2'b01; repeat (3) tick();
    idle();

    // ARF to RF route
    ARF_OutCSel = 2'b10; MuxASel = 2'b11; RF_FunSel = 2'b10; RF_RegSel = 4'b0111;
    tick();
    chk("route_r1", {24'h0, dut.R1}, 32'h03);
    chk("route_others", {8'h0, dut.R2, dut.R3, dut.R4}, 32'h0);

    // memory write/read, RF and IR loads from memory
    load_rf(0, 8'h5A);
    ARF_OutDSel = 2'b10;
    #1 chk("mem_alu_out", {24'h0, dut.ALUOut}, 32'h5A);
    Mem_CS = 1'b0; Mem_WR = 1'b1;
    tick();
    Mem_WR = 1'b0;
    #1 chk("mem_read", {24'h0, dut.MemoryOut}, 32'h5A);
    MuxASel = 2'b01; RF_FunSel = 2'b10; RF_RegSel = 4'b1101;
    tick();
    chk("r3_from_mem", {24'h0, dut.R3}, 32'h5A);
    RF_RegSel = 4'hF;
    IR_LH = 1'b1; IR_Enable = 1'b1; IR_Funsel = 2'b10;
    tick();
    chk("ir_load_hi", {16'h0, dut.IROut}, 32'h5A00);
    IR_Enable = 1'b0; IR_Funsel = 2'b11;
    tick();
    chk("ir_hold", {16'h0, dut.IROut}, 32'h5A00);
    IR_Enable = 1'b1; IR_LH = 1'b0; IR_Funsel = 2'b10;
    tick();
    chk("ir_load_lo", {16'h0, dut.IROut}, 32'h5A5A);
    IR_Funsel = 2'b11; tick();
    IR_Funsel = 2'b00; tick();
    chk("ir_dec_wrap", {16'h0, dut.IROut}, 32'hFFFF);
    idle();

    // reset mid-sequence while PC is counting
    ARF_RegSel = 3'b011; ARF_FunSel = 2'b01; ARF_OutDSel = 2'b10;
    tick();
    chk("pc_before_reset", {24'h0, dut.Address}, 32'h04);
    Reset_n = 1'b0;
    #1;
    chk("async_reset_regs", {dut.PC, dut.R3, dut.IROut}, 32'h0);
    @(posedge Clock); #1;
    chk("reset_holds_pc", {24'h0, dut.PC}, 32'h0);
    idle();
    Reset_n = 1'b1;
    tick();

    // ALU vector table
    for (int i = 0; i < 13; i++) begin
      load_rf(0, vecs[i].a);
      load_rf(1, vecs[i].b);
      RF_OutASel = 2'b11; RF_OutBSel = 2'b11; ALU_FunSel = 4'h6;
      tick();
      if (!vecs[i].cin) begin
        ALU_FunSel = 4'hB;
        tick();
      end
      RF_OutASel = 2'b00; RF_OutBSel = 2'b01; MuxCSel = 1'b0; ALU_FunSel = vecs[i].op;
      #1 chk($sformatf("vec%0d_alu_out", i), {24'h0, dut.ALUOut}, {24'h0, vecs[i].res});
      tick();
      chk($sformatf("vec%0d_flags", i), {28'h0, dut.ALUOutFlag}, {28'h0, vecs[i].flags});
    end

    // random stimulus against the behavioural model
    idle();
    Reset_n = 1'b0;
    #1 Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h0;
    m_pc = 0; m_ar = 0; m_sp = 0; m_ir = 0; m_flags = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h0;
    m_mem[3] = 8'h5A;

    for (int n = 0; n < 400; n++) begin
      r = $urandom(); r2 = $urandom();
      RF_OutASel = r[1:0]; RF_OutBSel = r[3:2]; RF_FunSel = r[5:4]; RF_RegSel = r[9:6];
      ALU_FunSel = r[13:10]; ARF_OutCSel = r[15:14]; ARF_OutDSel = r[17:16];
      ARF_FunSel = r[19:18]; ARF_RegSel = r[22:20]; IR_LH = r[23]; IR_Enable = r[24];
      IR_Funsel = r[26:25]; Mem_WR = r[27]; Mem_CS = r[28]; MuxASel = r[30:29];
      MuxBSel = r2[1:0]; MuxCSel = r2[2];
      #1;
      e_a  = m_rf[RF_OutASel];
      e_b  = m_rf[RF_OutBSel];
      e_c  = arf_pick(ARF_OutCSel);
      e_d  = arf_pick(ARF_OutDSel);
      e_mc = MuxCSel ? e_c : e_a;
      alu_model(ALU_FunSel, e_mc, e_b, m_flags, e_alu, e_flags);
      e_mem = (!Mem_CS && !Mem_WR) ? m_mem[e_d] : 8'h0;
      case (MuxASel)
        2'b00: e_mux_a = e_alu;
        2'b01: e_mux_a = e_mem;
        2'b10: e_mux_a = m_ir[7:0];
        default: e_mux_a = e_c;
      endcase
      case (MuxBSel)
        2'b00: e_mux_b = e_alu;
        2'b01: e_mux_b = e_mem;
        2'b10: e_mux_b = m_ir[7:0];
        default: e_mux_b = e_c;
      endcase
      chk($sformatf("rnd%0d_comb", n), {8'h0, dut.ALUOut, dut.MemoryOut, dut.Address}, {8'h0, e_alu, e_mem, e_d});
      tick();
      for (int k = 0; k < 4; k++)
        if (!RF_RegSel[3-k]) m_rf[k] = reg_fun(RF_FunSel, m_rf[k], e_mux_a);
      if (!ARF_RegSel[2]) m_pc = reg_fun(ARF_FunSel, m_pc, e_mux_b);
      if (!ARF_RegSel[1]) m_ar = reg_fun(ARF_FunSel, m_ar, e_mux_b);
      if (!ARF_RegSel[0]) m_sp = reg_fun(ARF_FunSel, m_sp, e_mux_b);
      if (IR_Enable) begin
        case (IR_Funsel)
          2'b00: m_ir = m_ir - 16'd1;
          2'b01: m_ir = m_ir + 16'd1;
          2'b10: if (IR_LH) m_ir[15:8] = e_mem; else m_ir[7:0] = e_mem;
          default: m_ir = 16'd0;
        endcase
      end
      m_flags = e_flags;
      if (!Mem_CS && Mem_WR) m_mem[e_d] = e_alu;
      chk($sformatf("rnd%0d_rf", n), {dut.R1, dut.R2, dut.R3, dut.R4}, {m_rf[0], m_rf[1], m_rf[2], m_rf[3]});
      chk($sformatf("rnd%0d_arf", n), {8'h0, dut.PC, dut.AR, dut.SP}, {8'h0, m_pc, m_ar, m_sp});
      chk($sformatf("rnd%0d_ir_flags", n), {12'h0, dut.ALUOutFlag, dut.IROut}, {12'h0, m_flags, m_ir});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
